// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule definitions: word type, round count,
// FSM state encoding and the small sigma functions of the schedule recurrence.
package sha256_pkg;

    typedef logic [31:0] word_t;

    // Schedule words emitted per 512-bit block.
    localparam int NROUNDS = 64;

    // Depth of the sliding window over W[t..t+15].
    localparam int NWORDS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_e;

    // sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
    function automatic word_t sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
    function automatic word_t sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_wnext.sv
// Next schedule word from the sliding window:
//   W[t+16] = sigma1(W[t+14]) + W[t+9] + sigma0(W[t+1]) + W[t]   (mod 2^32)
// Purely combinational; the caller registers the result.
module sha256_wnext
    import sha256_pkg::*;
(
    input  word_t w0,
    input  word_t w1,
    input  word_t w9,
    input  word_t w14,
    output word_t wnew
);

    // Four-operand modular sum; carries out of bit 31 are discarded.
    assign wnew = sigma1(w14) + w9 + sigma0(w1) + w0;

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule generator.
// Loads a 512-bit block into a 16-word window on start, then streams the
// 64 schedule words W[0..63] with a round index for the round-constant mux.
// Optional feature: define SHA256_SCHED_BACKPRESSURE_EN to add the wt_ready
// input; otherwise every valid beat is consumed and RUN lasts 64 cycles.
module sha256_msg_sched #(
    parameter int NROUNDS = sha256_pkg::NROUNDS
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [511:0] block,
    output logic         ready,
    output logic         wt_valid,
`ifdef SHA256_SCHED_BACKPRESSURE_EN
    input  logic         wt_ready,
`endif
    output logic [31:0]  wt,
    output logic [5:0]   count,
    output logic         last,
    output logic         done
);
    import sha256_pkg::*;

    localparam logic [5:0] LAST_IDX = 6'(NROUNDS - 1);

    sched_state_e state_q, state_d;
    logic [5:0]   count_q, count_d;
    logic         ready_q, ready_d;
    logic         valid_q, valid_d;
    logic         done_q,  done_d;
    word_t        sr_q     [NWORDS];
    word_t        sr_d     [NWORDS];
    word_t        blk_words[NWORDS];
    word_t        sr_shift [NWORDS];
    word_t        wnew;
    logic         accept;

    // Split the block so that slot 0 holds M0 (the most significant word).
    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_unpack
            assign blk_words[gi] = block[511 - 32*gi -: 32];
        end
    endgenerate

    // Window advanced by one word: every slot moves down, slot 15 takes W[t+16].
    generate
        for (gi = 0; gi < NWORDS - 1; gi++) begin : g_shift
            assign sr_shift[gi] = sr_q[gi + 1];
        end
    endgenerate
    assign sr_shift[NWORDS-1] = wnew;

    sha256_wnext u_wnext (
        .w0   (sr_q[0]),
        .w1   (sr_q[1]),
        .w9   (sr_q[9]),
        .w14  (sr_q[14]),
        .wnew (wnew)
    );

`ifdef SHA256_SCHED_BACKPRESSURE_EN
    assign accept = valid_q & wt_ready;
`else
    assign accept = valid_q;
`endif

    // Next-state logic for the IDLE -> RUN -> DONE sequence and the window.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ready_d = ready_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        sr_d    = sr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sr_d    = blk_words;
                    count_d = 6'd0;
                    state_d = ST_RUN;
                    ready_d = 1'b0;
                    valid_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    sr_d    = sr_shift;
                    // Wraps 63 -> 0 on the final beat.
                    count_d = count_q + 6'd1;
                    if (count_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
            end
        endcase
    end

    // State, window and registered handshake flags; reset aborts any block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= 6'd0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NWORDS; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            sr_q    <= sr_d;
        end
    end

    assign ready    = ready_q;
    assign wt_valid = valid_q;
    assign wt       = sr_q[0];
    assign count    = count_q;
    assign last     = valid_q & (count_q == LAST_IDX);
    assign done     = done_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed testbench for sha256_msg_sched. Expected schedule words come from
// an array-form reference of the SHA-256 recurrence plus hand constants.
module tb_sha256_msg_sched;

    localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    localparam logic [511:0] BLK_B   = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF,
                                        {11{32'h5A5A5A5A}}, 32'h00000200};

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [511:0] block;
    logic         ready;
    logic         wt_valid;
    logic [31:0]  wt;
    logic [5:0]   count;
    logic         last;
    logic         done;
`ifdef SHA256_SCHED_BACKPRESSURE_EN
    logic         wt_ready;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_w [64];
    logic [31:0] obs_w [64];
    logic [31:0] ref_w [64];

    always #5 clk = ~clk;

    sha256_msg_sched dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .block    (block),
        .ready    (ready),
        .wt_valid (wt_valid),
`ifdef SHA256_SCHED_BACKPRESSURE_EN
        .wt_ready (wt_ready),
`endif
        .wt       (wt),
        .count    (count),
        .last     (last),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ts0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ts1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_sched(input logic [511:0] b);
        for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            exp_w[t] = ts1(exp_w[t-2]) + exp_w[t-7] + ts0(exp_w[t-15]) + exp_w[t-16];
    endtask

    // Streams one block and checks every beat against the reference.
    // Returns on the sample where done should be high.
    task automatic run_block(input logic [511:0] b, input bit do_start,
                             input int stall_at, input int pulse_at);
        int  idx = 0;
        int  stall_left = 3;
        int  vcnt = 0;
        int  guard = 0;
        bit  pulsed = 1'b0;
        logic acc;
        build_sched(b);
        if (do_start) begin
            start = 1'b1;
            block = b;
            step();
            start = 1'b0;
        end
        chk("first_valid", wt_valid, 1'b1);
        chk("first_count", count, 32'd0);
        while (idx < 64 && guard < 300) begin
            guard++;
            chk("beat_valid", wt_valid, 1'b1);
            if (!wt_valid) break;
            vcnt++;
            chk($sformatf("count@%0d", idx), count, idx);
            chk($sformatf("wt@%0d", idx), wt, exp_w[idx]);
            chk($sformatf("last@%0d", idx), last, (idx == 63));
            obs_w[idx] = wt;
            if (idx == pulse_at && !pulsed) begin
                chk("ready_in_run", ready, 1'b0);
                start  = 1'b1;
                block  = ~b;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
                block = b;
            end
`ifdef SHA256_SCHED_BACKPRESSURE_EN
            if (idx == stall_at && stall_left > 0) begin
                wt_ready = 1'b0;
                stall_left--;
            end else begin
                wt_ready = 1'b1;
            end
            acc = wt_valid & wt_ready;
`else
            acc = wt_valid;
`endif
            step();
            if (acc) idx++;
        end
        start = 1'b0;
        chk("beats_done", idx, 32'd64);
        if (stall_at < 0) chk("valid_run_len", vcnt, 32'd64);
        chk("done_pulse", done, 1'b1);
        chk("done_valid_low", wt_valid, 1'b0);
        chk("done_count_wrap", count, 32'd0);
        chk("done_last_low", last, 1'b0);
        chk("done_ready_low", ready, 1'b0);
        $display("block W0=%08h beats=%0d valid_cycles=%0d W63=%08h", exp_w[0], idx, vcnt, obs_w[63]);
    endtask

    initial begin
        int g;
        int diffs;
        reset_n = 1'b0;
        start   = 1'b0;
        block   = '0;
`ifdef SHA256_SCHED_BACKPRESSURE_EN
        wt_ready = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1'b1);
        chk("rst_valid", wt_valid, 1'b0);
        chk("rst_wt", wt, 32'h0);
        chk("rst_count", count, 32'd0);
        chk("rst_last", last, 1'b0);
        chk("rst_done", done, 1'b0);
        @(negedge clk) reset_n = 1'b1;
        step();
        chk("idle_ready", ready, 1'b1);

        // "abc" block, no stall.
        run_block(BLK_ABC, 1'b1, -1, -1);
        chk("abc_W0", obs_w[0], 32'h61626380);
        chk("abc_W16", obs_w[16], 32'h61626380);
        chk("abc_W17", obs_w[17], 32'h000F0000);
        chk("abc_W63", obs_w[63], 32'h12B1EDEB);
        for (int i = 0; i < 64; i++) ref_w[i] = obs_w[i];
        step();
        chk("done_one_cycle", done, 1'b0);
        chk("back_to_idle", ready, 1'b1);

`ifdef SHA256_SCHED_BACKPRESSURE_EN
        // Three stall cycles at count 20.
        run_block(BLK_ABC, 1'b1, 20, -1);
        diffs = 0;
        for (int i = 0; i < 64; i++) if (obs_w[i] !== ref_w[i]) diffs++;
        chk("stall_seq_same", diffs, 32'd0);
        step();
`endif

        // start pulsed mid-run at count 5 must be ignored.
        run_block(BLK_ABC, 1'b1, -1, 5);
        diffs = 0;
        for (int i = 0; i < 64; i++) if (obs_w[i] !== ref_w[i]) diffs++;
        chk("pulse_seq_same", diffs, 32'd0);
        step();
        chk("pulse_idle_ready", ready, 1'b1);

        // Reset dropped at count 30.
        start = 1'b1;
        block = BLK_ABC;
        step();
        start = 1'b0;
        g = 0;
        while (count != 6'd30 && g < 100) begin
            step();
            g++;
        end
        chk("reach_count30", count, 32'd30);
        reset_n = 1'b0;
        #1;
        chk("arst_ready", ready, 1'b1);
        chk("arst_valid", wt_valid, 1'b0);
        chk("arst_wt", wt, 32'h0);
        chk("arst_count", count, 32'd0);
        chk("arst_last", last, 1'b0);
        chk("arst_done", done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("arst_no_done", done, 1'b0);
        end
        @(negedge clk) reset_n = 1'b1;
        step();
        chk("post_rst_done", done, 1'b0);
        chk("post_rst_ready", ready, 1'b1);
        chk("post_rst_valid", wt_valid, 1'b0);
        run_block(BLK_B, 1'b1, -1, -1);
        chk("blkB_W0", obs_w[0], 32'hDEADBEEF);

        // Back-to-back: start held from the done cycle into the following IDLE cycle.
        start = 1'b1;
        block = BLK_ABC;
        step();
        chk("start_in_done_ignored", wt_valid, 1'b0);
        chk("idle_after_done", ready, 1'b1);
        step();
        run_block(BLK_ABC, 1'b0, -1, -1);
        chk("b2b_W0", obs_w[0], 32'h61626380);
        step();
        chk("final_ready", ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard bound on total simulated time.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/sha256_msg_sched.md
SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

Interface
REQ-001 SHALL have parameter NROUNDS, default 64, giving the number of schedule words emitted per block (fixed at 64 for SHA-256).
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to load a new block.
REQ-006 SHALL have port block, input, 512 bits: the message block; M0 is in bits [511:480] and M15 in bits [31:0].
REQ-007 SHALL have port ready, output, 1 bit: high in IDLE, meaning start will be accepted.
REQ-008 SHALL have port wt_valid, output, 1 bit: wt and count are valid.
REQ-009 SHALL have port wt_ready, input, 1 bit: the downstream stage accepts the current beat (present only under the macro in REQ-021).
REQ-010 SHALL have port wt, output, 32 bits: schedule word W[count].
REQ-011 SHALL have port count, output, 6 bits: round index 0..63; this is the select for the downstream 64:1 round-constant mux.
REQ-012 SHALL have port last, output, 1 bit: wt_valid AND count==63.
REQ-013 SHALL have port done, output, 1 bit: single-cycle pulse after the final beat is accepted.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE:
- IDLE goes to RUN on start.
- RUN goes to DONE on acceptance of the beat with count==63.
- DONE goes to IDLE unconditionally after one cycle.
REQ-015 On start in IDLE, SHALL load a 16-word shift register with slot i = M_i and set count=0; wt_valid SHALL rise in the next cycle, giving a latency of 1 cycle.
REQ-016 A beat is accepted when wt_valid AND wt_ready are both high. On acceptance, the block SHALL:
- shift slot i to slot i-1;
- write slot 15 with sigma1(slot14) + slot9 + sigma0(slot1) + slot0, computed mod 2^32;
- increment count.
REQ-017 SHALL define wt as slot0; sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
REQ-018 While wt_valid is high and wt_ready is low, wt, count, last and all state SHALL hold stable.
REQ-019 start SHALL be ignored outside IDLE, including start asserted in the same cycle as done.
REQ-020 count SHALL wrap from 63 to 0 on the final acceptance; done SHALL be high only in DONE; wt_valid SHALL be low in IDLE and DONE.

Configuration
REQ-021 With the macro SHA256_SCHED_BACKPRESSURE_EN defined, the wt_ready port SHALL exist and gate acceptance as stated in REQ-016.
REQ-022 Without SHA256_SCHED_BACKPRESSURE_EN, the wt_ready port SHALL be absent, acceptance SHALL be wt_valid alone, and RUN SHALL take exactly 64 consecutive cycles.

Reset
REQ-023 While reset_n is low, the block SHALL force:
- state = IDLE;
- count = 0;
- shift register = 0;
- outputs: ready=1, wt_valid=0, wt=0, last=0, done=0.
REQ-024 Reset asserted mid-RUN SHALL abort the block immediately, with no done pulse; after release the block SHALL be in IDLE.

Structure
REQ-025 SHALL define the following in shared package sha256_pkg:
- word_t (32-bit typedef);
- NROUNDS;
- functions sigma0 and sigma1.
REQ-026 SHALL place the next-word adder tree in sub-module sha256_wnext, with inputs w0, w1, w9 and w14 and output wnew.
REQ-027 The schedule FSM and the shift register SHALL remain in sha256_msg_sched.

Verification
REQ-028 Bench SHALL load the padded "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018), with no stall, and check:
- W0=0x61626380;
- W16=0x61626380;
- W17=0x000F0000;
- W63=0x12B1EDEB;
- done exactly 1 cycle after count=63.
REQ-029 Bench SHALL drive the "abc" block with wt_ready low for 3 cycles at count=20, and check that wt and count hold and the W sequence is identical to the no-stall run.
REQ-030 Bench SHALL pulse start during RUN at count=5 and check that it is ignored (ready=0, sequence unaffected).
REQ-031 Bench SHALL drop reset_n at count=30 and check:
- all outputs return to reset values asynchronously;
- no done pulse;
- a new start gives W0 of the new block.
REQ-032 Bench SHALL issue two back-to-back blocks, with start asserted in the IDLE cycle immediately after done, and check that the second block starts with count=0 and a correct W0.
REQ-033 Bench SHALL build without SHA256_SCHED_BACKPRESSURE_EN and check that wt_valid is high for exactly 64 consecutive cycles with count 0..63.
